// File: rtl/ysyx_25040111_pcgen.sv
// Handshaked next-PC issue unit: holds one PC in flight, offers it to the IFU and
// waits for the EXU to resolve the next PC; supports flush/epoch, halt and misalign trapping.
module ysyx_25040111_pcgen #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h80000000,
  parameter int              IALIGN   = 4,
  parameter int              EPOCH_W  = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pc_valid,
  input  logic               pc_ready,
  output logic [XLEN-1:0]    pc_addr,
  output logic [EPOCH_W-1:0] pc_epoch,
  input  logic               upd_valid,
  input  logic [1:0]         upd_opt,
  input  logic               upd_brench,
  input  logic               upd_mret,
  input  logic [XLEN-1:0]    upd_mret_addr,
  input  logic [XLEN-1:0]    upd_imm,
  input  logic [XLEN-1:0]    upd_rs1,
  input  logic               flush,
  input  logic [XLEN-1:0]    flush_addr,
  input  logic               halt,
  output logic               misalign,
  output logic [XLEN-1:0]    misalign_addr,
  output logic [1:0]         dbg_state
);

  // S_MISAL is WAIT after a misaligned target: no issue and updates are ignored until flush.
  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HALT  = 2'd2,
    S_MISAL = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] STRIDE     = XLEN'(IALIGN);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
  localparam logic [XLEN-1:0] JALR_MASK  = {{(XLEN-1){1'b1}}, 1'b0};

  state_t              r_state, w_state_nxt;
  logic [XLEN-1:0]     r_pc, w_pc_nxt;
  logic [EPOCH_W-1:0]  r_epoch, w_epoch_nxt;
  logic                r_mis, w_mis_nxt;
  logic [XLEN-1:0]     r_mis_addr, w_mis_addr_nxt;

  logic [XLEN-1:0]     w_base, w_off, w_sum, w_tgt;
  logic                w_aligned;

  always_comb begin
    w_base = r_pc;
    w_off  = '0;
    case (upd_opt)
      2'b00: if (upd_brench) w_off = upd_imm;
      2'b01: w_off = STRIDE;
      2'b10: w_off = upd_imm;
      default: begin
        w_base = upd_rs1;
        w_off  = upd_imm;
      end
    endcase
    w_sum = w_base + w_off;
    if (upd_mret)
      w_tgt = upd_mret_addr;
    else if (upd_opt == 2'b11)
      w_tgt = w_sum & JALR_MASK;
    else
      w_tgt = w_sum;
    w_aligned = ((w_tgt & ALIGN_MASK) == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_ISSUE;
      r_pc       <= RESET_PC;
      r_epoch    <= '0;
      r_mis      <= 1'b0;
      r_mis_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_epoch    <= w_epoch_nxt;
      r_mis      <= w_mis_nxt;
      r_mis_addr <= w_mis_addr_nxt;
    end
  end

  // Handshake: pc_addr is transferred on a rising edge where pc_valid & pc_ready are both
  // high; while pc_valid is high and pc_ready low, pc_addr and pc_epoch hold steady.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_epoch_nxt    = r_epoch;
    w_mis_nxt      = 1'b0;
    w_mis_addr_nxt = r_mis_addr;
    if (flush) begin
      w_state_nxt = S_ISSUE;
      w_pc_nxt    = flush_addr;
      w_epoch_nxt = r_epoch + 1'b1;
    end else if (halt) begin
      w_state_nxt = S_HALT;
    end else begin
      case (r_state)
        S_ISSUE: if (pc_ready) w_state_nxt = S_WAIT;
        S_WAIT: begin
          if (upd_valid) begin
            if (w_aligned) begin
              w_pc_nxt    = w_tgt;
              w_state_nxt = S_ISSUE;
            end else begin
              w_mis_nxt      = 1'b1;
              w_mis_addr_nxt = w_tgt;
              w_state_nxt    = S_MISAL;
            end
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    pc_valid      = (r_state == S_ISSUE);
    pc_addr       = r_pc;
    pc_epoch      = r_epoch;
    misalign      = r_mis;
    misalign_addr = r_mis_addr;
    dbg_state     = r_state;
  end

  upd_only_in_wait: assert property (@(posedge clk) disable iff (reset)
    upd_valid |-> (r_state == S_WAIT || r_state == S_MISAL || flush || halt));

endmodule

// File: tb/tb_ysyx_25040111_pcgen.sv
// Directed bench for the PC issue unit: issued PCs and misalign pulses are checked by
// monitors against expected queues; an IALIGN=2 instance shares the stimulus.
module tb_ysyx_25040111_pcgen;
  localparam int XLEN = 32;
  localparam int EW   = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            pc_ready = 1'b0;
  logic            upd_valid = 1'b0;
  logic [1:0]      upd_opt = 2'b00;
  logic            upd_brench = 1'b0;
  logic            upd_mret = 1'b0;
  logic [XLEN-1:0] upd_mret_addr = '0;
  logic [XLEN-1:0] upd_imm = '0;
  logic [XLEN-1:0] upd_rs1 = '0;
  logic            flush = 1'b0;
  logic [XLEN-1:0] flush_addr = '0;
  logic            halt = 1'b0;

  logic            pc_valid, misalign;
  logic [XLEN-1:0] pc_addr, misalign_addr;
  logic [EW-1:0]   pc_epoch;
  logic [1:0]      dbg_state;

  logic            d2_pc_valid, d2_misalign;
  logic [XLEN-1:0] d2_pc_addr, d2_misalign_addr;
  logic [EW-1:0]   d2_pc_epoch;
  logic [1:0]      d2_dbg_state;

  logic [XLEN+EW-1:0] exp_q[$];
  logic [XLEN-1:0]    mis_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  ysyx_25040111_pcgen #(.XLEN(XLEN), .RESET_PC(32'h80000000), .IALIGN(4), .EPOCH_W(EW)) u_dut (
    .clk(clk), .reset(reset), .pc_valid(pc_valid), .pc_ready(pc_ready), .pc_addr(pc_addr),
    .pc_epoch(pc_epoch), .upd_valid(upd_valid), .upd_opt(upd_opt), .upd_brench(upd_brench),
    .upd_mret(upd_mret), .upd_mret_addr(upd_mret_addr), .upd_imm(upd_imm), .upd_rs1(upd_rs1),
    .flush(flush), .flush_addr(flush_addr), .halt(halt), .misalign(misalign),
    .misalign_addr(misalign_addr), .dbg_state(dbg_state));

  ysyx_25040111_pcgen #(.XLEN(XLEN), .RESET_PC(32'h80000000), .IALIGN(2), .EPOCH_W(EW)) u_dut2 (
    .clk(clk), .reset(reset), .pc_valid(d2_pc_valid), .pc_ready(pc_ready), .pc_addr(d2_pc_addr),
    .pc_epoch(d2_pc_epoch), .upd_valid(upd_valid), .upd_opt(upd_opt), .upd_brench(upd_brench),
    .upd_mret(upd_mret), .upd_mret_addr(upd_mret_addr), .upd_imm(upd_imm), .upd_rs1(upd_rs1),
    .flush(flush), .flush_addr(flush_addr), .halt(halt), .misalign(d2_misalign),
    .misalign_addr(d2_misalign_addr), .dbg_state(d2_dbg_state));

  // clock / reset
  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitors
  always @(negedge clk) begin
    if (!reset && pc_valid && pc_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL issue: got unexpected pc %h epoch %0d, expected none", pc_addr, pc_epoch);
      end else begin
        chk("issue", {30'b0, pc_epoch, pc_addr}, {30'b0, exp_q.pop_front()});
      end
    end
    if (!reset && misalign) begin
      if (mis_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL misalign: got unexpected pulse addr %h, expected none", misalign_addr);
      end else begin
        chk("misalign_addr", {32'b0, misalign_addr}, {32'b0, mis_q.pop_front()});
      end
    end
  end

  // drivers
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic expect_pc(input logic [XLEN-1:0] a, input logic [EW-1:0] e);
    exp_q.push_back({e, a});
  endtask

  task automatic take_pc();
    pc_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pc_valid) begin
        @(posedge clk); #1;
        pc_ready = 1'b0;
        return;
      end
    end
    pc_ready = 1'b0;
    chk("take_pc_timeout", 64'd1, 64'd0);
  endtask

  task automatic update(input logic [1:0] opt, input logic br, input logic mr,
                        input logic [XLEN-1:0] maddr, input logic [XLEN-1:0] imm,
                        input logic [XLEN-1:0] rs1);
    upd_opt = opt; upd_brench = br; upd_mret = mr;
    upd_mret_addr = maddr; upd_imm = imm; upd_rs1 = rs1;
    upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0; upd_mret = 1'b0; upd_brench = 1'b0;
  endtask

  task automatic do_flush(input logic [XLEN-1:0] a, input logic rdy);
    flush = 1'b1; flush_addr = a; pc_ready = rdy;
    tick();
    flush = 1'b0; pc_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_valid", {63'b0, pc_valid}, 64'd1);
    chk("rst_pc", {32'b0, pc_addr}, 64'h80000000);
    chk("rst_epoch", {62'b0, pc_epoch}, 64'd0);
    chk("rst_misalign", {63'b0, misalign}, 64'd0);
    chk("rst_mis_addr", {32'b0, misalign_addr}, 64'd0);

    expect_pc(32'h80000000, 2'd0);
    take_pc();
    chk("wait_valid", {63'b0, pc_valid}, 64'd0);

    // sequential stride and wrap
    update(2'b01, 1'b0, 1'b0, '0, '0, '0);
    chk("seq_valid_latency", {63'b0, pc_valid}, 64'd1);
    expect_pc(32'h80000004, 2'd0); take_pc();
    do_flush(32'hFFFFFFFC, 1'b0);
    expect_pc(32'hFFFFFFFC, 2'd1); take_pc();
    update(2'b01, 1'b0, 1'b0, '0, '0, '0);
    expect_pc(32'h00000000, 2'd1); take_pc();

    // conditional branch taken / not taken
    do_flush(32'h80000004, 1'b0);
    expect_pc(32'h80000004, 2'd2); take_pc();
    update(2'b00, 1'b1, 1'b0, '0, 32'hFFFFFFF0, '0);
    expect_pc(32'h7FFFFFF4, 2'd2); take_pc();
    do_flush(32'h80000004, 1'b0);
    expect_pc(32'h80000004, 2'd3); take_pc();
    update(2'b00, 1'b0, 1'b0, '0, 32'hFFFFFFF0, '0);
    expect_pc(32'h80000004, 2'd3); take_pc();

    // JALR: bit 0 cleared; misaligned for IALIGN=4, fine for IALIGN=2
    mis_q.push_back(32'h80001002);
    update(2'b11, 1'b0, 1'b0, '0, 32'h0, 32'h80001003);
    chk("jalr_misalign_pulse", {63'b0, misalign}, 64'd1);
    chk("ialign2_pc", {32'b0, d2_pc_addr}, 64'h80001002);
    chk("ialign2_valid", {63'b0, d2_pc_valid}, 64'd1);
    chk("ialign2_no_mis", {31'b0, d2_misalign, d2_misalign_addr}, 64'd0);
    chk("ialign2_state", {62'b0, d2_dbg_state}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mis_no_issue", {63'b0, pc_valid}, 64'd0);
      chk("mis_pulse_end", {63'b0, misalign}, 64'd0);
    end
    chk("mis_addr_held", {32'b0, misalign_addr}, 64'h80001002);
    chk("mis_pc_kept", {32'b0, pc_addr}, 64'h80000004);
    do_flush(32'h80000100, 1'b0);
    chk("ialign2_flush_epoch", {62'b0, d2_pc_epoch}, 64'd0);
    expect_pc(32'h80000100, 2'd0); take_pc();

    // backpressure then flush colliding with acceptance
    update(2'b01, 1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_pc", {32'b0, pc_addr}, 64'h80000104);
      chk("stall_valid", {63'b0, pc_valid}, 64'd1);
    end
    expect_pc(32'h80000104, 2'd0);
    do_flush(32'h80000300, 1'b1);
    expect_pc(32'h80000300, 2'd1); take_pc();
    do_flush(32'h80000310, 1'b0);
    do_flush(32'h80000320, 1'b0);
    do_flush(32'h80000400, 1'b0);
    chk("epoch_wrap", {62'b0, pc_epoch}, 64'd0);
    expect_pc(32'h80000400, 2'd0); take_pc();

    // mret overrides upd_opt
    update(2'b01, 1'b0, 1'b1, 32'h80000200, '0, '0);
    expect_pc(32'h80000200, 2'd0); take_pc();

    // halt, then reset out of it
    halt = 1'b1; tick(); halt = 1'b0;
    chk("halt_state", {62'b0, dbg_state}, 64'd2);
    pc_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt_valid", {63'b0, pc_valid}, 64'd0);
    end
    pc_ready = 1'b0;
    reset = 1'b1; #1;
    chk("async_rst_pc", {32'b0, pc_addr}, 64'h80000000);
    tick(); reset = 1'b0;
    chk("rerst_valid", {63'b0, pc_valid}, 64'd1);
    chk("rerst_epoch", {62'b0, pc_epoch}, 64'd0);
    expect_pc(32'h80000000, 2'd0); take_pc();

    repeat (2) tick();
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("mis_q_empty", 64'(mis_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
